// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: the reset PC,
// the bubble encoding, the fetch FSM state type and an address helper.
package fetch_stage_pkg;

  // Default PC loaded on reset (word aligned)
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // sll $0,$0,0 -- the canonical MIPS no-op, used for every bubble
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  // BOOT issues the very first read; RUN is the steady fetch state
  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } FetchState;

  // Instruction addresses are always word aligned, so the low two bits are dropped
  function automatic logic [31:0] alignAddr(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: hazard-unit
// controls, the ID-stage redirect, the instruction memory port and the
// IF/ID pipeline register outputs.
interface fetch_stage_if;

  logic        PCWrite;
  logic        IF_ID_Write;
  logic        PCSrc;
  logic [31:0] Branch_Target;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;

  // Surrounding pipeline / memory side
  modport master (
    output PCWrite, IF_ID_Write, PCSrc, Branch_Target, imem_rdata,
    input  imem_addr, imem_rd_en, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid
  );

  // Fetch stage side
  modport slave (
    input  PCWrite, IF_ID_Write, PCSrc, Branch_Target, imem_rdata,
    output imem_addr, imem_rd_en, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter, its +4 incrementer and the next-PC selection.
// The selected next PC doubles as the memory read address, because the
// memory registers the address at the same edge that the PC does.
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        runEn,
  input  logic        pcWrite,
  input  logic        ifIdWrite,
  input  logic        pcSrc,
  input  logic [31:0] branchTarget,
  output logic [31:0] pcPlus4,
  output logic [31:0] nextPc
);

  logic [31:0] pc;

  // Next PC: a stall outranks a redirect because the branch is still parked in ID
  always_comb begin
    pcPlus4 = pc + 32'd4;
    nextPc  = pc;
    if (runEn) begin
      if (!ifIdWrite) begin
        nextPc = pc;
      end else if (pcSrc) begin
        nextPc = alignAddr(branchTarget);
      end else if (pcWrite) begin
        nextPc = pcPlus4;
      end
    end
  end

  // PC register; holds itself outside RUN since nextPc equals pc there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= alignAddr(RESET_PC);
    end else begin
      pc <= nextPc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register. A one-cycle BOOT state primes the
// synchronous-read instruction memory; after that the stage fetches one word
// per cycle, holding on a hazard stall and inserting one bubble per redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.slave bus
);

  FetchState   state;
  FetchState   nextState;
  logic        runEn;
  logic [31:0] pcPlus4;
  logic [31:0] nextPc;

  logic [31:0] ifIdPc4;
  logic [31:0] ifIdInstr;
  logic        ifIdValid;
  logic [31:0] ifIdPc4Next;
  logic [31:0] ifIdInstrNext;
  logic        ifIdValidNext;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) pcReg (
    .clk         (clk),
    .rst         (rst),
    .runEn       (runEn),
    .pcWrite     (bus.PCWrite),
    .ifIdWrite   (bus.IF_ID_Write),
    .pcSrc       (bus.PCSrc),
    .branchTarget(bus.Branch_Target),
    .pcPlus4     (pcPlus4),
    .nextPc      (nextPc)
  );

  // FSM state register; reset always returns to BOOT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= nextState;
    end
  end

  // FSM next state: BOOT lasts exactly one cycle, RUN persists until reset
  always_comb begin
    nextState = state;
    runEn     = 1'b0;
    case (state)
      BOOT: begin
        nextState = RUN;
      end
      RUN: begin
        nextState = RUN;
        runEn     = 1'b1;
      end
      default: begin
        nextState = BOOT;
      end
    endcase
  end

  // IF/ID next value: bubble in BOOT, hold on stall, flush on redirect, else load
  always_comb begin
    ifIdPc4Next   = ifIdPc4;
    ifIdInstrNext = ifIdInstr;
    ifIdValidNext = ifIdValid;
    if (!runEn) begin
      ifIdPc4Next   = 32'd0;
      ifIdInstrNext = NOP_INSTR;
      ifIdValidNext = 1'b0;
    end else if (bus.IF_ID_Write) begin
      ifIdPc4Next = pcPlus4;
      if (bus.PCSrc) begin
        ifIdInstrNext = NOP_INSTR;
        ifIdValidNext = 1'b0;
      end else begin
        ifIdInstrNext = bus.imem_rdata;
        ifIdValidNext = 1'b1;
      end
    end
  end

  // IF/ID pipeline register; reset forces a bubble immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifIdPc4   <= 32'd0;
      ifIdInstr <= NOP_INSTR;
      ifIdValid <= 1'b0;
    end else begin
      ifIdPc4   <= ifIdPc4Next;
      ifIdInstr <= ifIdInstrNext;
      ifIdValid <= ifIdValidNext;
    end
  end

  assign bus.imem_addr   = nextPc;
  assign bus.imem_rd_en  = 1'b1;
  assign bus.IF_ID_PC4   = ifIdPc4;
  assign bus.IF_ID_Instr = ifIdInstr;
  assign bus.IF_ID_Valid = ifIdValid;

  // The hazard unit must never advance the PC while freezing IF/ID
  illegalStallCombo: assert property (
    @(posedge clk) disable iff (rst)
    (state == RUN) |-> !(bus.PCWrite && !bus.IF_ID_Write)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a stimulus process drives hazard and
// redirect inputs and pushes the expected per-cycle view into a queue from a
// program-order reference model; a monitor pops and compares on every
// falling edge. Memory word at address a is 32'h1000_0000 + a/4.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP      = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] addr;
  } Expect;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_stage_if busIf ();

  fetch_stage #(
    .RESET_PC (TB_RESET_PC),
    .NOP_INSTR(TB_NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf)
  );

  Expect expQ[$];
  int    checksDone   = 0;
  int    checksPassed = 0;

  // Reference model: where fetch stands in program order, and what IF/ID shows
  bit          mBoot;
  logic [31:0] mPc;
  logic [31:0] mPc4;
  logic [31:0] mInstr;
  logic        mValid;

  // Free-running core clock
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Synchronous-read instruction memory with one cycle of latency
  always @(posedge clk) begin
    if (busIf.imem_rd_en) busIf.imem_rdata <= memWord(busIf.imem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksDone++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus; the expected view for this cycle is queued and the model advances
  task automatic applyStimulus(input bit stall, input bit branch, input logic [31:0] target);
    Expect e;
    @(posedge clk);
    #1;
    rst                 = 1'b0;
    busIf.PCWrite       = !stall;
    busIf.IF_ID_Write   = !stall;
    busIf.PCSrc         = branch;
    busIf.Branch_Target = target;
    e.pc4   = mPc4;
    e.instr = mInstr;
    e.valid = mValid;
    if (mBoot) begin
      e.addr = mPc;
      mBoot  = 1'b0;
      mPc4   = 32'd0;
      mInstr = TB_NOP;
      mValid = 1'b0;
    end else if (stall) begin
      e.addr = mPc;
    end else if (branch) begin
      e.addr = {target[31:2], 2'b00};
      mPc4   = mPc + 32'd4;
      mInstr = TB_NOP;
      mValid = 1'b0;
      mPc    = e.addr;
    end else begin
      e.addr = mPc + 32'd4;
      mPc4   = mPc + 32'd4;
      mInstr = memWord(mPc);
      mValid = 1'b1;
      mPc    = e.addr;
    end
    expQ.push_back(e);
  endtask

  // Mid-cycle reset during a stall with a redirect pending; rst stays high afterwards
  task automatic doReset(input int holdCycles);
    Expect e;
    @(posedge clk);
    #1;
    busIf.PCWrite       = 1'b0;
    busIf.IF_ID_Write   = 1'b0;
    busIf.PCSrc         = 1'b1;
    busIf.Branch_Target = 32'h0000_0200;
    #1;
    rst    = 1'b1;
    mBoot  = 1'b1;
    mPc    = TB_RESET_PC;
    mPc4   = 32'd0;
    mInstr = TB_NOP;
    mValid = 1'b0;
    e = Expect'{pc4: 32'd0, instr: TB_NOP, valid: 1'b0, addr: TB_RESET_PC};
    expQ.push_back(e);
    repeat (holdCycles) begin
      @(posedge clk);
      #1;
      expQ.push_back(e);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation every falling edge
  initial begin
    Expect e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("imem_addr", busIf.imem_addr, e.addr);
        checkOutput("imem_rd_en", {31'd0, busIf.imem_rd_en}, 32'd1);
        checkOutput("IF_ID_PC4", busIf.IF_ID_PC4, e.pc4);
        checkOutput("IF_ID_Instr", busIf.IF_ID_Instr, e.instr);
        checkOutput("IF_ID_Valid", {31'd0, busIf.IF_ID_Valid}, {31'd0, e.valid});
      end
    end
  end

  // Directed scenarios, then a randomized run, then a reset in the middle of a stall
  initial begin
    int r;
    busIf.PCWrite       = 1'b0;
    busIf.IF_ID_Write   = 1'b0;
    busIf.PCSrc         = 1'b0;
    busIf.Branch_Target = 32'd0;
    mBoot  = 1'b1;
    mPc    = TB_RESET_PC;
    mPc4   = 32'd0;
    mInstr = TB_NOP;
    mValid = 1'b0;

    doReset(2);
    applyStimulus(0, 0, 32'd0);
    applyStimulus(0, 0, 32'd0);
    applyStimulus(0, 0, 32'd0);
    applyStimulus(1, 0, 32'd0);
    applyStimulus(1, 0, 32'd0);
    applyStimulus(0, 0, 32'd0);
    applyStimulus(0, 1, 32'h0000_0043);
    applyStimulus(0, 0, 32'd0);
    applyStimulus(0, 0, 32'd0);
    applyStimulus(1, 1, 32'h0000_0100);
    applyStimulus(0, 1, 32'h0000_0100);
    applyStimulus(0, 0, 32'd0);
    applyStimulus(0, 1, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 32'd0);
    applyStimulus(0, 0, 32'd0);
    applyStimulus(0, 0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) applyStimulus(1, 1'($urandom_range(0, 1)), $urandom);
      else if (r == 3) applyStimulus(0, 1, $urandom);
      else applyStimulus(0, 0, $urandom);
    end

    applyStimulus(1, 1, 32'h0000_0080);
    doReset(1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 32'd0);
    applyStimulus(0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
